// File: rtl/mem_bridge_if.sv
// CPU-side and physical-memory-side signal bundle for mem_bridge.
// The slave modport is the bridge's view; master is the environment's view.
interface mem_bridge_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_enable;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;

  logic              pmem_req;
  logic              pmem_we;
  logic [ADDR_W-1:0] pmem_addr;
  logic [DATA_W-1:0] pmem_wdata;
  logic [BE_W-1:0]   pmem_be;
  logic              pmem_ready;
  logic [DATA_W-1:0] pmem_rdata;

  logic              timeout_err;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  pmem_ready, pmem_rdata,
    output mem_resp, mem_rdata,
    output pmem_req, pmem_we, pmem_addr, pmem_wdata, pmem_be,
    output timeout_err
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output pmem_ready, pmem_rdata,
    input  mem_resp, mem_rdata,
    input  pmem_req, pmem_we, pmem_addr, pmem_wdata, pmem_be,
    input  timeout_err
  );
endinterface

// File: rtl/mem_bridge.sv
// Single-outstanding CPU-to-physical-memory bridge with a bounded wait
// for pmem_ready and a sticky timeout flag.
module mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_bridge_if.slave  bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              we_q, we_d;
  logic              resp_q, resp_d;
  logic              req_q, req_d;
  logic              pwe_q, pwe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              terr_q, terr_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      resp_q  <= 1'b0;
      req_q   <= 1'b0;
      pwe_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '1;
      rdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      we_q    <= we_d;
      resp_q  <= resp_d;
      req_q   <= req_d;
      pwe_q   <= pwe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state and next-output logic; outputs are derived from the next state
  // so they appear registered in the same cycle the state takes effect.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    terr_d  = terr_q;

    case (state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          state_d = BUSY;
          cnt_d   = '0;
          we_d    = bus.mem_write;
          addr_d  = bus.mem_address & WORD_MASK;
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_write ? bus.mem_byte_enable : '1;
        end
      end
      BUSY: begin
        if (bus.pmem_ready) begin
          state_d = DONE;
          if (!we_q) rdata_d = bus.pmem_rdata;
        end else begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state_d = DONE;
            rdata_d = '0;
            terr_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    resp_d = (state_d == DONE);
    req_d  = (state_d == BUSY);
    pwe_d  = (state_d == BUSY) && we_d;
  end

  assign bus.mem_resp    = resp_q;
  assign bus.mem_rdata   = rdata_q;
  assign bus.pmem_req    = req_q;
  assign bus.pmem_we     = pwe_q;
  assign bus.pmem_addr   = addr_q;
  assign bus.pmem_wdata  = wdata_q;
  assign bus.pmem_be     = be_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge with a short timeout (TIMEOUT_CYCLES=4).
module tb_mem_bridge;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_bridge_if bus();

  mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = 32'h0;
    bus.mem_wdata       = 32'h0;
    bus.mem_byte_enable = 4'h0;
    bus.pmem_ready      = 1'b0;
    bus.pmem_rdata      = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.mem_resp !== 1'b0) $display("FAIL rst_resp got %b want 0", bus.mem_resp); else n_pass++;
    n_checks++; if (bus.pmem_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus.pmem_req); else n_pass++;
    n_checks++; if (bus.pmem_we !== 1'b0) $display("FAIL rst_we got %b want 0", bus.pmem_we); else n_pass++;
    n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL rst_terr got %b want 0", bus.timeout_err); else n_pass++;
    n_checks++; if (bus.mem_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", bus.mem_rdata); else n_pass++;
    n_checks++; if (bus.pmem_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", bus.pmem_addr); else n_pass++;
    n_checks++; if (bus.pmem_wdata !== 32'h0) $display("FAIL rst_wdata got %h want 0", bus.pmem_wdata); else n_pass++;
    n_checks++; if (bus.pmem_be !== 4'hF) $display("FAIL rst_be got %h want f", bus.pmem_be); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.pmem_req !== 1'b0) $display("FAIL idle_req got %b want 0", bus.pmem_req); else n_pass++;
  endtask

  task automatic test_read();
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_1006;
    tick();  // BUSY 1
    n_checks++; if (bus.pmem_req !== 1'b1) $display("FAIL rd_req got %b want 1", bus.pmem_req); else n_pass++;
    n_checks++; if (bus.pmem_addr !== 32'h0000_1004) $display("FAIL rd_addr got %h want 00001004", bus.pmem_addr); else n_pass++;
    n_checks++; if (bus.pmem_we !== 1'b0) $display("FAIL rd_we got %b want 0", bus.pmem_we); else n_pass++;
    n_checks++; if (bus.pmem_be !== 4'hF) $display("FAIL rd_be got %h want f", bus.pmem_be); else n_pass++;
    bus.mem_address = 32'hFFFF_FFFF;
    tick();  // BUSY 2, CPU address change must be ignored
    n_checks++; if (bus.pmem_addr !== 32'h0000_1004) $display("FAIL rd_addr_hold got %h want 00001004", bus.pmem_addr); else n_pass++;
    n_checks++; if (bus.mem_resp !== 1'b0) $display("FAIL rd_early_resp got %b want 0", bus.mem_resp); else n_pass++;
    tick();  // BUSY 3
    bus.pmem_ready = 1'b1;
    bus.pmem_rdata = 32'hDEAD_BEEF;
    tick();  // DONE
    n_checks++; if (bus.mem_resp !== 1'b1) $display("FAIL rd_resp got %b want 1", bus.mem_resp); else n_pass++;
    n_checks++; if (bus.mem_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata got %h want deadbeef", bus.mem_rdata); else n_pass++;
    n_checks++; if (bus.pmem_req !== 1'b0) $display("FAIL rd_done_req got %b want 0", bus.pmem_req); else n_pass++;
    idle_inputs();
    tick();  // IDLE
    n_checks++; if (bus.mem_resp !== 1'b0) $display("FAIL rd_resp_pulse got %b want 0", bus.mem_resp); else n_pass++;
  endtask

  task automatic test_write();
    bus.mem_write       = 1'b1;
    bus.mem_address     = 32'h0000_0020;
    bus.mem_wdata       = 32'h1234_5678;
    bus.mem_byte_enable = 4'b0011;
    bus.pmem_ready      = 1'b1;  // stray in IDLE, then the first BUSY cycle
    bus.pmem_rdata      = 32'hCAFE_F00D;
    tick();  // BUSY (N+1)
    n_checks++; if (bus.pmem_req !== 1'b1) $display("FAIL wr_req got %b want 1", bus.pmem_req); else n_pass++;
    n_checks++; if (bus.pmem_we !== 1'b1) $display("FAIL wr_we got %b want 1", bus.pmem_we); else n_pass++;
    n_checks++; if (bus.pmem_be !== 4'b0011) $display("FAIL wr_be got %b want 0011", bus.pmem_be); else n_pass++;
    n_checks++; if (bus.pmem_wdata !== 32'h1234_5678) $display("FAIL wr_wdata got %h want 12345678", bus.pmem_wdata); else n_pass++;
    n_checks++; if (bus.pmem_addr !== 32'h0000_0020) $display("FAIL wr_addr got %h want 00000020", bus.pmem_addr); else n_pass++;
    tick();  // DONE (N+2)
    n_checks++; if (bus.mem_resp !== 1'b1) $display("FAIL wr_resp got %b want 1", bus.mem_resp); else n_pass++;
    n_checks++; if (bus.mem_rdata !== 32'hDEAD_BEEF) $display("FAIL wr_rdata_keep got %h want deadbeef", bus.mem_rdata); else n_pass++;
    n_checks++; if (bus.pmem_we !== 1'b0) $display("FAIL wr_done_we got %b want 0", bus.pmem_we); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_0100;
    bus.pmem_ready  = 1'b1;
    bus.pmem_rdata  = 32'h1111_1111;
    tick();  // BUSY
    tick();  // DONE
    n_checks++; if (bus.mem_rdata !== 32'h1111_1111) $display("FAIL b2b_rdata1 got %h want 11111111", bus.mem_rdata); else n_pass++;
    n_checks++; if (bus.pmem_req !== 1'b0) $display("FAIL b2b_gap_done got %b want 0", bus.pmem_req); else n_pass++;
    bus.mem_address = 32'h0000_0200;
    bus.pmem_rdata  = 32'h2222_2222;
    tick();  // IDLE, stray ready in DONE ignored
    n_checks++; if (bus.mem_rdata !== 32'h1111_1111) $display("FAIL b2b_stray got %h want 11111111", bus.mem_rdata); else n_pass++;
    n_checks++; if (bus.pmem_req !== 1'b0) $display("FAIL b2b_idle_req got %b want 0", bus.pmem_req); else n_pass++;
    n_checks++; if (bus.mem_resp !== 1'b0) $display("FAIL b2b_idle_resp got %b want 0", bus.mem_resp); else n_pass++;
    tick();  // second BUSY
    n_checks++; if (bus.pmem_req !== 1'b1) $display("FAIL b2b_req2 got %b want 1", bus.pmem_req); else n_pass++;
    n_checks++; if (bus.pmem_addr !== 32'h0000_0200) $display("FAIL b2b_addr2 got %h want 00000200", bus.pmem_addr); else n_pass++;
    tick();  // second DONE
    n_checks++; if (bus.mem_resp !== 1'b1) $display("FAIL b2b_resp2 got %b want 1", bus.mem_resp); else n_pass++;
    n_checks++; if (bus.mem_rdata !== 32'h2222_2222) $display("FAIL b2b_rdata2 got %h want 22222222", bus.mem_rdata); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_rw_both();
    bus.mem_read        = 1'b1;
    bus.mem_write       = 1'b1;
    bus.mem_address     = 32'h0000_0040;
    bus.mem_wdata       = 32'hA5A5_A5A5;
    bus.mem_byte_enable = 4'b1010;
    tick();  // BUSY
    n_checks++; if (bus.pmem_we !== 1'b1) $display("FAIL rw_we got %b want 1", bus.pmem_we); else n_pass++;
    n_checks++; if (bus.pmem_be !== 4'b1010) $display("FAIL rw_be got %b want 1010", bus.pmem_be); else n_pass++;
    n_checks++; if (bus.pmem_addr !== 32'h0000_0040) $display("FAIL rw_addr got %h want 00000040", bus.pmem_addr); else n_pass++;
    bus.pmem_ready = 1'b1;
    bus.pmem_rdata = 32'h5555_5555;
    tick();  // DONE
    n_checks++; if (bus.mem_rdata !== 32'h2222_2222) $display("FAIL rw_rdata_keep got %h want 22222222", bus.mem_rdata); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_0080;
    tick();  // BUSY 1
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.pmem_req !== 1'b1 || bus.mem_resp !== 1'b0) $display("FAIL to_busy%0d got req=%b resp=%b want req=1 resp=0", i, bus.pmem_req, bus.mem_resp); else n_pass++;
      tick();
    end
    n_checks++; if (bus.mem_resp !== 1'b1) $display("FAIL to_resp got %b want 1", bus.mem_resp); else n_pass++;
    n_checks++; if (bus.pmem_req !== 1'b0) $display("FAIL to_req got %b want 0", bus.pmem_req); else n_pass++;
    n_checks++; if (bus.mem_rdata !== 32'h0) $display("FAIL to_rdata got %h want 0", bus.mem_rdata); else n_pass++;
    n_checks++; if (bus.timeout_err !== 1'b1) $display("FAIL to_terr got %b want 1", bus.timeout_err); else n_pass++;
    idle_inputs();
    tick();
    // a good write afterwards must leave the flag set
    bus.mem_write  = 1'b1;
    bus.pmem_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.mem_resp !== 1'b1) $display("FAIL to_good_resp got %b want 1", bus.mem_resp); else n_pass++;
    n_checks++; if (bus.timeout_err !== 1'b1) $display("FAIL to_sticky got %b want 1", bus.timeout_err); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_0300;
    tick();
    n_checks++; if (bus.pmem_req !== 1'b1) $display("FAIL mr_req_pre got %b want 1", bus.pmem_req); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.pmem_req !== 1'b0) $display("FAIL mr_req_async got %b want 0", bus.pmem_req); else n_pass++;
    n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL mr_terr got %b want 0", bus.timeout_err); else n_pass++;
    n_checks++; if (bus.pmem_addr !== 32'h0 || bus.pmem_wdata !== 32'h0 || bus.pmem_be !== 4'hF) $display("FAIL mr_latched got addr=%h wdata=%h be=%h want 0 0 f", bus.pmem_addr, bus.pmem_wdata, bus.pmem_be); else n_pass++;
    n_checks++; if (bus.mem_resp !== 1'b0 || bus.pmem_we !== 1'b0 || bus.mem_rdata !== 32'h0) $display("FAIL mr_outs got resp=%b we=%b rdata=%h want 0 0 0", bus.mem_resp, bus.pmem_we, bus.mem_rdata); else n_pass++;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.mem_resp !== 1'b0 || bus.pmem_req !== 1'b0) $display("FAIL mr_after%0d got resp=%b req=%b want 0 0", i, bus.mem_resp, bus.pmem_req); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_rw_both();
    test_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
